// File: rtl/bcd_7seg_pkg.sv
// Shared constants for the BCD seven-segment scan driver.
// Segment order is {a,b,c,d,e,f,g}, with a in the MSB. Codes 10..15 show a dash.
package bcd_7seg_pkg;

    localparam int SEG_W = 7;

    localparam logic [SEG_W-1:0] SEG_OFF = 7'b0000000;
    localparam logic [SEG_W-1:0] DASH    = 7'b0000001;

    localparam logic [SEG_W-1:0] SEG_TABLE [16] = '{
        7'b1111110,  // 0
        7'b0110000,  // 1
        7'b1101101,  // 2
        7'b1111001,  // 3
        7'b0110011,  // 4
        7'b1011011,  // 5
        7'b1011111,  // 6
        7'b1110000,  // 7
        7'b1111111,  // 8
        7'b1111011,  // 9
        DASH, DASH, DASH, DASH, DASH, DASH
    };

    function automatic logic [SEG_W-1:0] bcd_to_seg(input logic [3:0] bcd);
        return SEG_TABLE[bcd];
    endfunction

endpackage

// File: rtl/bcd_7seg_scan_driver_if.sv
// Bundle between the BCD producer (master) and the scan driver (slave).
// The display-pin outputs travel back to the master side.
interface bcd_7seg_scan_driver_if
    import bcd_7seg_pkg::*;
#(
    parameter int NUM_DIGITS = 4
);

    logic [4*NUM_DIGITS-1:0] bcd_in;
    logic [NUM_DIGITS-1:0]   dp_in;
    logic                    load;
    logic                    blank;
    logic [SEG_W-1:0]        seg;
    logic                    dp;
    logic [NUM_DIGITS-1:0]   an;
    logic                    frame_done;

    modport master (
        output bcd_in, dp_in, load, blank,
        input  seg, dp, an, frame_done
    );

    modport slave (
        input  bcd_in, dp_in, load, blank,
        output seg, dp, an, frame_done
    );

endinterface

// File: rtl/bcd_7seg_scan_driver_decode.sv
// Combinational BCD to seven-segment decoder, active-high segments.
module bcd_seg_decode
    import bcd_7seg_pkg::*;
(
    input  logic [3:0]       i_bcd,
    output logic [SEG_W-1:0] o_seg
);

    assign o_seg = bcd_to_seg(i_bcd);

endmodule

// File: rtl/bcd_7seg_scan_driver.sv
// Time-multiplexed N-digit seven-segment driver.
// The display register only changes on a frame boundary, so a frame never
// mixes digits from two different values. A short dead time opens each slot
// to stop the previous digit ghosting onto the next anode.
module bcd_7seg_scan_driver
    import bcd_7seg_pkg::*;
#(
    parameter int NUM_DIGITS     = 4,
    parameter int REFRESH_DIV    = 50000,
    parameter int DEAD_CYCLES    = 2,
    parameter int LZ_SUPPRESS    = 1,
    parameter int SEG_ACTIVE_LOW = 0,
    parameter int AN_ACTIVE_LOW  = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    bcd_7seg_scan_driver_if.slave bus
);

    localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [SEG_W-1:0]      SEG_INV = {SEG_W{SEG_ACTIVE_LOW != 0}};
    localparam logic                  DP_INV  = (SEG_ACTIVE_LOW != 0);
    localparam logic [NUM_DIGITS-1:0] AN_INV  = {NUM_DIGITS{AN_ACTIVE_LOW != 0}};

    logic [CNT_W-1:0]        r_cnt;
    logic [IDX_W-1:0]        r_idx;
    logic [4*NUM_DIGITS-1:0] r_display;
    logic [NUM_DIGITS-1:0]   r_dispDp;
    logic [4*NUM_DIGITS-1:0] r_pendBcd;
    logic [NUM_DIGITS-1:0]   r_pendDp;
    logic                    r_pendValid;
    logic                    r_frameDone;
    logic [SEG_W-1:0]        r_seg;
    logic                    r_dp;
    logic [NUM_DIGITS-1:0]   r_an;

    logic                    w_slotEnd;
    logic                    w_frameEnd;
    logic                    w_live;
    logic                    w_anOn;
    logic [NUM_DIGITS-1:0]   w_anOneHot;
    logic [3:0]              w_digit;
    logic                    w_digitDp;
    logic                    w_suppress;
    logic                    w_zeroRun;
    logic [SEG_W-1:0]        w_decSeg;

    assign w_slotEnd  = (r_cnt == CNT_W'(REFRESH_DIV - 1));
    assign w_frameEnd = w_slotEnd && (r_idx == IDX_W'(NUM_DIGITS - 1));
    assign w_anOneHot = NUM_DIGITS'(1) << r_idx;
    assign w_anOn     = w_live && !bus.blank;

    generate
        if (DEAD_CYCLES == 0) begin : g_noDead
            assign w_live = 1'b1;
        end else begin : g_dead
            assign w_live = (r_cnt >= CNT_W'(DEAD_CYCLES));
        end
    endgenerate

    // Prescaler and digit index: one slot per REFRESH_DIV cycles, blank has no effect here.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt       <= '0;
            r_idx       <= '0;
            r_frameDone <= 1'b0;
        end else begin
            r_frameDone <= w_frameEnd;
            if (w_slotEnd) begin
                r_cnt <= '0;
                if (r_idx == IDX_W'(NUM_DIGITS - 1)) begin
                    r_idx <= '0;
                end else begin
                    r_idx <= r_idx + 1'b1;
                end
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    // Load path: a load arriving on frame end goes straight to the display, else it waits in pending.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_display   <= '0;
            r_dispDp    <= '0;
            r_pendBcd   <= '0;
            r_pendDp    <= '0;
            r_pendValid <= 1'b0;
        end else if (bus.load && w_frameEnd) begin
            r_display   <= bus.bcd_in;
            r_dispDp    <= bus.dp_in;
            r_pendValid <= 1'b0;
        end else begin
            if (w_frameEnd && r_pendValid) begin
                r_display   <= r_pendBcd;
                r_dispDp    <= r_pendDp;
                r_pendValid <= 1'b0;
            end
            if (bus.load) begin
                r_pendBcd   <= bus.bcd_in;
                r_pendDp    <= bus.dp_in;
                r_pendValid <= 1'b1;
            end
        end
    end

    // Select the active digit and decide whether it is a suppressed leading zero.
    always_comb begin
        w_digit    = 4'd0;
        w_digitDp  = 1'b0;
        w_suppress = 1'b0;
        w_zeroRun  = 1'b1;
        for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
            if (r_display[4*k +: 4] != 4'd0) begin
                w_zeroRun = 1'b0;
            end
            if (r_idx == IDX_W'(k)) begin
                w_digit    = r_display[4*k +: 4];
                w_digitDp  = r_dispDp[k];
                w_suppress = (LZ_SUPPRESS != 0) && (k != 0) && w_zeroRun;
            end
        end
    end

    bcd_seg_decode u_decode (
        .i_bcd (w_digit),
        .o_seg (w_decSeg)
    );

    // Registered pin stage: segments and dp are forced off whenever no anode is enabled.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_an  <= AN_INV;
            r_seg <= SEG_OFF ^ SEG_INV;
            r_dp  <= DP_INV;
        end else if (w_anOn) begin
            r_an  <= w_anOneHot ^ AN_INV;
            r_seg <= (w_suppress ? SEG_OFF : w_decSeg) ^ SEG_INV;
            r_dp  <= w_digitDp ^ DP_INV;
        end else begin
            r_an  <= AN_INV;
            r_seg <= SEG_OFF ^ SEG_INV;
            r_dp  <= DP_INV;
        end
    end

    assign bus.an         = r_an;
    assign bus.seg        = r_seg;
    assign bus.dp         = r_dp;
    assign bus.frame_done = r_frameDone;

endmodule

// File: tb/tb_bcd_7seg_scan_driver.sv
// Directed bench for the seven-segment scan driver: 4 digits, 4-cycle slots,
// 1 dead cycle. A second instance with leading-zero suppression off shares the inputs.
module tb_bcd_7seg_scan_driver;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    logic [3:0] capAn   [16];
    logic [6:0] capSeg  [16];
    logic       capDp   [16];
    logic [3:0] capAnB  [16];
    logic [6:0] capSegB [16];
    logic       capDpB  [16];

    bcd_7seg_scan_driver_if #(.NUM_DIGITS(4)) busA ();
    bcd_7seg_scan_driver_if #(.NUM_DIGITS(4)) busB ();

    assign busB.bcd_in = busA.bcd_in;
    assign busB.dp_in  = busA.dp_in;
    assign busB.load   = busA.load;
    assign busB.blank  = busA.blank;

    bcd_7seg_scan_driver #(
        .NUM_DIGITS(4), .REFRESH_DIV(4), .DEAD_CYCLES(1),
        .LZ_SUPPRESS(1), .SEG_ACTIVE_LOW(0), .AN_ACTIVE_LOW(1)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (busA)
    );

    bcd_7seg_scan_driver #(
        .NUM_DIGITS(4), .REFRESH_DIV(4), .DEAD_CYCLES(1),
        .LZ_SUPPRESS(0), .SEG_ACTIVE_LOW(0), .AN_ACTIVE_LOW(1)
    ) dutNoLz (
        .clk (clk),
        .rst (rst),
        .bus (busB)
    );

    always #5 clk = ~clk;

    // Expected {an,seg,dp} for frame step s (0..15); segs packs digit k at [7k+:7].
    function automatic logic [11:0] exp_out(input int s, input logic [27:0] segs, input logic [3:0] dps);
        int idx;
        logic [3:0] anv;
        idx = s / 4;
        if (s % 4 == 0) return {4'b1111, 7'b0000000, 1'b0};
        anv = ~(4'b0001 << idx);
        return {anv, segs[7*idx +: 7], dps[idx]};
    endfunction

    task automatic do_load(input logic [15:0] v, input logic [3:0] d);
        busA.bcd_in = v;
        busA.dp_in  = d;
        busA.load   = 1'b1;
        @(negedge clk);
        busA.load   = 1'b0;
    endtask

    task automatic wait_frame(input string name);
        int n;
        n = 0;
        while (busA.frame_done !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (busA.frame_done !== 1'b1) begin
            errors++;
            $display("[TB] FAIL %s: frame_done got %b want 1 within 40 cycles", name, busA.frame_done);
        end
    endtask

    task automatic capture_frame();
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            capAn[k]   = busA.an;
            capSeg[k]  = busA.seg;
            capDp[k]   = busA.dp;
            capAnB[k]  = busB.an;
            capSegB[k] = busB.seg;
            capDpB[k]  = busB.dp;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        busA.load = 1'b0;
        busA.blank = 1'b0;
        busA.bcd_in = '0;
        busA.dp_in = '0;
        repeat (3) @(negedge clk);
        checks += 4;
        if (busA.an !== 4'b1111) begin errors++; $display("[TB] FAIL reset_an: got %b want 1111", busA.an); end
        if (busA.seg !== 7'b0000000) begin errors++; $display("[TB] FAIL reset_seg: got %b want 0000000", busA.seg); end
        if (busA.dp !== 1'b0) begin errors++; $display("[TB] FAIL reset_dp: got %b want 0", busA.dp); end
        if (busA.frame_done !== 1'b0) begin errors++; $display("[TB] FAIL reset_fd: got %b want 0", busA.frame_done); end
        rst = 1'b0;
        for (int n = 1; n <= 33; n++) begin
            @(negedge clk);
            checks++;
            if (busA.frame_done !== (n == 16 || n == 32)) begin
                errors++;
                $display("[TB] FAIL reset_fd_period n=%0d: got %b want %b", n, busA.frame_done, (n == 16 || n == 32));
            end
        end
    endtask

    task automatic test_digits();
        logic [11:0] e;
        do_load(16'h1234, 4'b0100);
        wait_frame("digits_frame");
        capture_frame();
        for (int s = 0; s < 16; s++) begin
            e = exp_out(s, {7'b0110000, 7'b1101101, 7'b1111001, 7'b0110011}, 4'b0100);
            checks++;
            if ({capAn[s], capSeg[s], capDp[s]} !== e) begin
                errors++;
                $display("[TB] FAIL digits s=%0d: got an=%b seg=%b dp=%b want %b", s, capAn[s], capSeg[s], capDp[s], e);
            end
        end
    endtask

    task automatic test_leading_zero();
        logic [11:0] e;
        do_load(16'h0007, 4'b0000);
        wait_frame("lz_frame");
        capture_frame();
        for (int s = 0; s < 16; s++) begin
            e = exp_out(s, {7'b0000000, 7'b0000000, 7'b0000000, 7'b1110000}, 4'b0000);
            checks++;
            if ({capAn[s], capSeg[s], capDp[s]} !== e) begin
                errors++;
                $display("[TB] FAIL lz_on s=%0d: got an=%b seg=%b dp=%b want %b", s, capAn[s], capSeg[s], capDp[s], e);
            end
            e = exp_out(s, {7'b1111110, 7'b1111110, 7'b1111110, 7'b1110000}, 4'b0000);
            checks++;
            if ({capAnB[s], capSegB[s], capDpB[s]} !== e) begin
                errors++;
                $display("[TB] FAIL lz_off s=%0d: got an=%b seg=%b dp=%b want %b", s, capAnB[s], capSegB[s], capDpB[s], e);
            end
        end
    endtask

    task automatic test_dash();
        logic [11:0] e;
        do_load(16'h00A5, 4'b0000);
        wait_frame("dash_frame");
        capture_frame();
        for (int s = 0; s < 16; s++) begin
            e = exp_out(s, {7'b0000000, 7'b0000000, 7'b0000001, 7'b1011011}, 4'b0000);
            checks++;
            if ({capAn[s], capSeg[s], capDp[s]} !== e) begin
                errors++;
                $display("[TB] FAIL dash_lz s=%0d: got an=%b seg=%b dp=%b want %b", s, capAn[s], capSeg[s], capDp[s], e);
            end
            e = exp_out(s, {7'b1111110, 7'b1111110, 7'b0000001, 7'b1011011}, 4'b0000);
            checks++;
            if ({capAnB[s], capSegB[s], capDpB[s]} !== e) begin
                errors++;
                $display("[TB] FAIL dash_nolz s=%0d: got an=%b seg=%b dp=%b want %b", s, capAnB[s], capSegB[s], capDpB[s], e);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [11:0] e;
        wait_frame("b2b_start");
        // Mid-frame load of 8888, then 4096 on the frame-end edge; the old value must hold all frame.
        for (int k = 1; k <= 16; k++) begin
            if (k == 6) begin
                busA.bcd_in = 16'h8888; busA.dp_in = 4'b1111; busA.load = 1'b1;
            end else if (k == 16) begin
                busA.bcd_in = 16'h4096; busA.dp_in = 4'b0001; busA.load = 1'b1;
            end else begin
                busA.load = 1'b0;
            end
            @(negedge clk);
            e = exp_out(k - 1, {7'b0000000, 7'b0000000, 7'b0000001, 7'b1011011}, 4'b0000);
            checks++;
            if ({busA.an, busA.seg, busA.dp} !== e) begin
                errors++;
                $display("[TB] FAIL b2b_old k=%0d: got an=%b seg=%b dp=%b want %b", k, busA.an, busA.seg, busA.dp, e);
            end
        end
        busA.load = 1'b0;
        checks++;
        if (busA.frame_done !== 1'b1) begin
            errors++;
            $display("[TB] FAIL b2b_fd: got %b want 1", busA.frame_done);
        end
        for (int f = 0; f < 2; f++) begin
            capture_frame();
            for (int s = 0; s < 16; s++) begin
                e = exp_out(s, {7'b0110011, 7'b1111110, 7'b1111011, 7'b1011111}, 4'b0001);
                checks++;
                if ({capAn[s], capSeg[s], capDp[s]} !== e) begin
                    errors++;
                    $display("[TB] FAIL b2b_new f=%0d s=%0d: got an=%b seg=%b dp=%b want %b", f, s, capAn[s], capSeg[s], capDp[s], e);
                end
            end
        end
    endtask

    task automatic test_blank();
        logic [11:0] e;
        // Starts on a frame boundary; blank is sampled on edges 3..12.
        for (int j = 1; j <= 20; j++) begin
            busA.blank = (j >= 3 && j <= 12);
            @(negedge clk);
            if (j >= 3 && j <= 12) e = {4'b1111, 7'b0000000, 1'b0};
            else e = exp_out((j - 1) % 16, {7'b0110011, 7'b1111110, 7'b1111011, 7'b1011111}, 4'b0001);
            checks++;
            if ({busA.an, busA.seg, busA.dp} !== e) begin
                errors++;
                $display("[TB] FAIL blank j=%0d: got an=%b seg=%b dp=%b want %b", j, busA.an, busA.seg, busA.dp, e);
            end
            if (j == 16) begin
                checks++;
                if (busA.frame_done !== 1'b1) begin
                    errors++;
                    $display("[TB] FAIL blank_fd: got %b want 1", busA.frame_done);
                end
            end
        end
        busA.blank = 1'b0;
    endtask

    task automatic test_reset_mid();
        logic [11:0] e;
        do_load(16'h5555, 4'b1111);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checks += 4;
        if (busA.an !== 4'b1111) begin errors++; $display("[TB] FAIL rstmid_an: got %b want 1111", busA.an); end
        if (busA.seg !== 7'b0000000) begin errors++; $display("[TB] FAIL rstmid_seg: got %b want 0000000", busA.seg); end
        if (busA.dp !== 1'b0) begin errors++; $display("[TB] FAIL rstmid_dp: got %b want 0", busA.dp); end
        if (busA.frame_done !== 1'b0) begin errors++; $display("[TB] FAIL rstmid_fd: got %b want 0", busA.frame_done); end
        rst = 1'b0;
        for (int n = 1; n <= 16; n++) begin
            @(negedge clk);
            checks++;
            if (busA.frame_done !== (n == 16)) begin
                errors++;
                $display("[TB] FAIL rstmid_fd n=%0d: got %b want %b", n, busA.frame_done, (n == 16));
            end
        end
        capture_frame();
        for (int s = 0; s < 16; s++) begin
            e = exp_out(s, {7'b0000000, 7'b0000000, 7'b0000000, 7'b1111110}, 4'b0000);
            checks++;
            if ({capAn[s], capSeg[s], capDp[s]} !== e) begin
                errors++;
                $display("[TB] FAIL rstmid_frame s=%0d: got an=%b seg=%b dp=%b want %b", s, capAn[s], capSeg[s], capDp[s], e);
            end
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout want completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        $display("[TB] starting scan driver bench");
        test_reset();
        test_digits();
        test_leading_zero();
        test_dash();
        test_back_to_back();
        test_blank();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
